// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO of {pc, instr} with
// valid/ready on both sides and a one-cycle flush for branch redirects.
module if_id_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     if_valid,
   input  logic [WIDTH-1:0]         if_instr,
   input  logic [WIDTH-1:0]         if_pc,
   output logic                     if_ready,
   input  logic                     flush,
   output logic                     id_valid,
   output logic [WIDTH-1:0]         id_instr,
   output logic [WIDTH-1:0]         id_pc,
   input  logic                     id_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] pc_mem    [DEPTH];
   logic [WIDTH-1:0] instr_mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   // Ready depends on occupancy only, so a full queue never passes a push through.
   assign if_ready = (count != FULL_COUNT);
   assign id_valid = (count != '0);
   assign push     = if_valid & if_ready & ~flush;
   assign pop      = id_valid & id_ready & ~flush;

   assign id_pc    = id_valid ? pc_mem[rd_ptr]    : '0;
   assign id_instr = id_valid ? instr_mem[rd_ptr] : '0;

   // Storage carries no reset; stale contents are masked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= if_pc;
         instr_mem[wr_ptr] <= if_instr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, fill/drain, streaming, full-with-pop,
// flush, async reset mid-stream and a wrap-around run against a queue model.
module tb_if_id_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic        if_ready;
   logic        flush;
   logic        id_valid;
   logic [15:0] id_instr;
   logic [15:0] id_pc;
   logic        id_ready;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   if_id_queue #(.DEPTH(4), .WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
      .flush(flush),
      .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   // Advance one clock edge, then settle away from it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] ins,
                        input logic rdy, input logic fl);
      if_valid = v; if_pc = pc; if_instr = ins; id_ready = rdy; flush = fl;
      #1;
   endtask

   logic [15:0] model_q[$];
   int pushed;
   int cycles;
   bit do_push;
   bit do_pop;

   initial begin
      rst = 1'b1;
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      check("reset_count", 32'(count), 32'd0);
      check("reset_if_ready", 32'(if_ready), 32'd1);
      check("reset_id_valid", 32'(id_valid), 32'd0);
      check("reset_id_pc", 32'(id_pc), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cyc();

      // Fill with decode stalled, then try a fifth push.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 16'(2*i), 16'(16'hA001 + i), 1'b0, 1'b0);
         cyc();
      end
      check("fill_count", 32'(count), 32'd4);
      check("fill_if_ready", 32'(if_ready), 32'd0);
      drive(1'b1, 16'h0008, 16'hA005, 1'b0, 1'b0);
      cyc();
      check("fill_drop_count", 32'(count), 32'd4);
      drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("drain_pc", 32'(id_pc), 32'(2*i));
         check("drain_instr", 32'(id_instr), 32'(16'hA001 + i));
         cyc();
      end
      check("drain_id_valid", 32'(id_valid), 32'd0);
      check("drain_empty_pc", 32'(id_pc), 32'h0);
      check("drain_empty_instr", 32'(id_instr), 32'h0);

      // Streaming: one push and one pop every cycle.
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 16'(2*i), 16'(16'hB000 + i), 1'b1, 1'b0);
         if (i > 0) check("stream_pc", 32'(id_pc), 32'(2*(i-1)));
         cyc();
         check("stream_count", 32'(count), 32'd1);
      end
      drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      check("stream_last_pc", 32'(id_pc), 32'h0026);
      cyc();
      check("stream_end_count", 32'(count), 32'd0);

      // Full with simultaneous pop: push is dropped, then accepted next cycle.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 16'(16'h0010 + 2*i), 16'(16'hC000 + i), 1'b0, 1'b0);
         cyc();
      end
      drive(1'b1, 16'h0018, 16'hC004, 1'b1, 1'b0);
      cyc();
      check("fullpop_count", 32'(count), 32'd3);
      check("fullpop_head", 32'(id_pc), 32'h0012);
      drive(1'b1, 16'h001A, 16'hC005, 1'b1, 1'b0);
      cyc();
      check("fullpop_count2", 32'(count), 32'd3);
      check("fullpop_head2", 32'(id_pc), 32'h0014);
      drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      check("fullpop_d0", 32'(id_pc), 32'h0014);
      cyc();
      check("fullpop_d1", 32'(id_pc), 32'h0016);
      cyc();
      check("fullpop_d2", 32'(id_pc), 32'h001A);
      check("fullpop_d2_instr", 32'(id_instr), 32'hC005);
      cyc();
      check("fullpop_empty", 32'(id_valid), 32'd0);

      // Flush with same-cycle push and pop.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'(16'h0020 + 2*i), 16'(16'hD000 + i), 1'b0, 1'b0);
         cyc();
      end
      check("preflush_count", 32'(count), 32'd3);
      drive(1'b1, 16'h0040, 16'hD040, 1'b1, 1'b1);
      cyc();
      check("flush_count", 32'(count), 32'd0);
      check("flush_id_valid", 32'(id_valid), 32'd0);
      check("flush_if_ready", 32'(if_ready), 32'd1);
      drive(1'b1, 16'h0100, 16'hD100, 1'b0, 1'b0);
      cyc();
      check("postflush_head", 32'(id_pc), 32'h0100);
      check("postflush_count", 32'(count), 32'd1);
      drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      cyc();
      check("postflush_empty", 32'(count), 32'd0);

      // Async reset mid-stream with count 3.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'(16'h0030 + 2*i), 16'(16'hE000 + i), 1'b0, 1'b0);
         cyc();
      end
      drive(1'b1, 16'h0036, 16'hE003, 1'b1, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      check("arst_count", 32'(count), 32'd0);
      check("arst_id_valid", 32'(id_valid), 32'd0);
      check("arst_if_ready", 32'(if_ready), 32'd1);
      check("arst_id_pc", 32'(id_pc), 32'h0);
      check("arst_id_instr", 32'(id_instr), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 16'h0050, 16'hE050, 1'b0, 1'b0);
      cyc();
      check("arst_first_push", 32'(id_pc), 32'h0050);
      drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      cyc();

      // Wrap-around: 13 entries through the queue with random decode stalls.
      pushed = 0;
      cycles = 0;
      model_q.delete();
      while ((pushed < 13 || model_q.size() != 0) && cycles < 300) begin
         drive(pushed < 13, 16'(16'h0300 + 2*pushed), 16'(16'hF000 + pushed),
               1'($urandom_range(0, 1)), 1'b0);
         check("wrap_if_ready", 32'(if_ready), 32'(model_q.size() != 4));
         do_push = if_valid && (model_q.size() != 4);
         do_pop  = id_ready && (model_q.size() != 0);
         if (do_pop) check("wrap_head", 32'(id_pc), 32'(model_q[0]));
         cyc();
         if (do_pop) void'(model_q.pop_front());
         if (do_push) begin
            model_q.push_back(16'(16'h0300 + 2*pushed));
            pushed++;
         end
         check("wrap_count", 32'(count), 32'(model_q.size()));
         cycles++;
      end
      check("wrap_completed", 32'(cycles < 300), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage and decode in the 16-bit pipeline. Captures each fetched {PC, instruction} pair into a DEPTH-entry FIFO and presents the oldest entry to decode with a valid/ready handshake. Absorbs decode stalls without losing fetched instructions and is cleared in one cycle on a branch redirect.

## Interface
- DEPTH, 4, entry count; power of two, at least 2.
- WIDTH, 16, instruction and PC width.

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- if_valid  input  1  fetch presents a valid entry this cycle.
- if_instr  input  WIDTH  fetched instruction.
- if_pc  input  WIDTH  PC of the fetched instruction.
- if_ready  output  1  queue accepts a push this cycle (not full).
- flush  input  1  discard all entries (branch taken / redirect).
- id_valid  output  1  head entry valid for decode.
- id_instr  output  WIDTH  head instruction; 16'h0000 when empty.
- id_pc  output  WIDTH  head PC; 16'h0000 when empty.
- id_ready  input  1  decode consumes the head entry this cycle.
- count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH-entry register array of {pc, instr}; write pointer, read pointer (log2(DEPTH) bits each, wrap modulo DEPTH), occupancy counter.
- push = if_valid & if_ready & ~flush; pop = id_valid & id_ready & ~flush.
- push: write {if_pc, if_instr} at write pointer, write pointer +1.
- pop: read pointer +1.
- count next = count + push - pop; push and pop in the same cycle leave count unchanged and are legal at any occupancy between 1 and DEPTH-1.
- if_ready = (count != DEPTH); combinational from count only, never from id_ready (no pass-through when full; a pop while full frees a slot for the next cycle).
- id_valid = (count != 0). No empty bypass: an entry pushed into an empty queue is not visible in the same cycle.
- id_instr/id_pc: combinational read of the array at the read pointer, forced to 16'h0000 when count == 0.
- flush: on the next edge, pointers and count return to 0; a same-cycle push is dropped and a same-cycle pop has no effect. Array contents are left unchanged (masked by count).
- Entries leave in strict push order; no reordering, duplication or loss except on flush or rst.
- Array contents need no reset; all outputs are defined by count/pointers.

## Timing
- Reset (async assert, any time, including mid-push/pop): pointers 0, count 0, id_valid 0, if_ready 1, id_instr 16'h0000, id_pc 16'h0000. Outputs take these values immediately on rst assertion; first push accepted on the first edge after deassertion.
- Push-to-visible latency: 1 cycle (pushed at edge N, id_valid/id_pc/id_instr valid after edge N).
- Throughput: one push and one pop per cycle sustained.
- Full (count == DEPTH): if_ready low; if_valid ignored.
- Empty (count == 0): id_ready ignored; outputs zero.
- flush asserted for one cycle: queue empty after that edge; if_ready 1 and id_valid 0 the following cycle.
- Pointer wrap: DEPTH-1 -> 0 with no bubble.

## Test plan
- Reset: assert rst mid-stream with count 3 -> count 0, id_valid 0, if_ready 1, id_pc/id_instr 16'h0000 without waiting for clk.
- Fill/drain: id_ready 0, push PCs 0x0000,0x0002,0x0004,0x0006 with instrs 0xA001..0xA004 -> count 4, if_ready 0, 5th push (PC 0x0008) dropped; then id_ready 1 for 4 cycles -> heads 0x0000..0x0006 in order, then id_valid 0.
- Streaming: if_valid and id_ready held 1 for 20 cycles from empty -> count stays 1 after first cycle, every PC 0x0000..0x0026 emerges exactly once, in order, one cycle after push.
- Full with pop: count 4, id_ready 1 and if_valid 1 same cycle -> head pops, push dropped (if_ready was 0), count 3; next cycle push accepted, count stays 3 with pop.
- Flush: count 3, assert flush with if_valid 1 (PC 0x0040) and id_ready 1 -> next cycle count 0, id_valid 0, PC 0x0040 never appears; next push PC 0x0100 appears as head after one cycle.
- Wrap-around: run 3*DEPTH+1 push/pop pairs with random id_ready stalls -> scoreboard matches push order, count never exceeds DEPTH or underflows.
